// File: rtl/mac_pkg.sv
// Shared widths and types for the MAC normalizer slice.
package mac_pkg;

  localparam int SUM_W  = 25;
  localparam int MANT_W = 11;
  localparam int DIFF_W = 5;
  localparam int EXP_W  = 6;
  localparam int QF_W   = 5;
  localparam int LOD_W  = 24;
  localparam int IDX_W  = 5;

  localparam logic signed [DIFF_W-1:0] DIFF_MIN = DIFF_W'(-16);
  localparam int SHIFT_CAP = 16;

  typedef struct packed {
    logic [MANT_W-1:0]        win;
    logic signed [DIFF_W-1:0] diff;
  } norm_t;

endpackage

// File: rtl/mac_norm_shift_if.sv
// Valid/ready stream bundle around the normalizer: upstream beat in, normalized beat out.
interface mac_norm_shift_if;

  logic                         in_valid;
  logic                         in_ready;
  logic [mac_pkg::SUM_W-1:0]    sum_mag;
  logic                         sign;
  logic [mac_pkg::EXP_W-1:0]    max_exp;
  logic [mac_pkg::QF_W-1:0]     Q_frac;

  logic                         out_valid;
  logic                         out_ready;
  logic [mac_pkg::MANT_W-1:0]   norm_sum_with_leading1;
  logic [mac_pkg::DIFF_W-1:0]   signed_exp_diff;
  logic                         exp_carry;
  logic                         sign_o;
  logic [mac_pkg::EXP_W-1:0]    max_exp_o;
  logic [mac_pkg::QF_W-1:0]     Q_frac_o;

  // Environment side: drives the input beat and the downstream ready.
  modport master (
    output in_valid, sum_mag, sign, max_exp, Q_frac, out_ready,
    input  in_ready, out_valid, norm_sum_with_leading1, signed_exp_diff,
           exp_carry, sign_o, max_exp_o, Q_frac_o
  );

  // Normalizer side.
  modport slave (
    input  in_valid, sum_mag, sign, max_exp, Q_frac, out_ready,
    output in_ready, out_valid, norm_sum_with_leading1, signed_exp_diff,
           exp_carry, sign_o, max_exp_o, Q_frac_o
  );

endinterface

// File: rtl/lod24.sv
// Combinational leading-one detector over a 24-bit vector: highest set index plus all-zero flag.
module lod24
  import mac_pkg::*;
(
  input  logic [LOD_W-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < LOD_W; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign zero = ~|vec;

endmodule

// File: rtl/mac_norm_shift.sv
// Two-stage normalizer: leading-one detect, then shift into an 11-bit window with exponent adjust.
// Define NORM_ROUND_EN for round-to-nearest-even on the window; default build truncates.
module mac_norm_shift
  import mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  mac_norm_shift_if.slave  bus
);

  logic                     vld_p1;
  logic [SUM_W-1:0]         mag_p1;
  logic [IDX_W-1:0]         lead_p1;
  logic                     zero_p1;
  logic                     carry_p1;
  logic                     sign_p1;
  logic [EXP_W-1:0]         exp_p1;
  logic [QF_W-1:0]          qf_p1;

  logic                     vld_p2;
  logic [MANT_W-1:0]        win_p2;
  logic signed [DIFF_W-1:0] diff_p2;
  logic                     carry_p2;
  logic                     sign_p2;
  logic [EXP_W-1:0]         exp_p2;
  logic [QF_W-1:0]          qf_p2;

  logic                     s2_advance;
  logic [IDX_W-1:0]         lead_idx;
  logic                     lead_zero;
  logic [IDX_W-1:0]         shamt_c;
  logic [LOD_W-1:0]         shifted_c;
  norm_t                    pre_c;
  norm_t                    post_c;

`ifdef NORM_ROUND_EN
  logic                     guard_c;
  logic                     sticky_c;

  // Overflow of an all-ones window renormalizes to the hidden one and bumps the exponent.
  function automatic norm_t round_rne(input norm_t in, input logic guard, input logic sticky);
    norm_t r;
    r = in;
    if (guard & (sticky | in.win[0])) begin
      if (&in.win) begin
        r.win  = MANT_W'(11'h400);
        r.diff = in.diff + 5'sd1;
      end else begin
        r.win  = in.win + 1'b1;
      end
    end
    return r;
  endfunction
`endif

  assign s2_advance  = !vld_p2 | bus.out_ready;
  assign bus.in_ready = !vld_p1 | s2_advance;

  lod24 u_lod24 (
    .vec  (bus.sum_mag[LOD_W-1:0]),
    .idx  (lead_idx),
    .zero (lead_zero)
  );

  // ---- stage 1: capture leading-one position and context ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      mag_p1   <= '0;
      lead_p1  <= '0;
      zero_p1  <= 1'b0;
      carry_p1 <= 1'b0;
      sign_p1  <= 1'b0;
      exp_p1   <= '0;
      qf_p1    <= '0;
    end else begin
      if (bus.in_ready) vld_p1 <= bus.in_valid;
      if (bus.in_valid && bus.in_ready) begin
        mag_p1   <= bus.sum_mag;
        lead_p1  <= lead_idx;
        zero_p1  <= lead_zero;
        carry_p1 <= bus.sum_mag[SUM_W-1];
        sign_p1  <= bus.sign;
        exp_p1   <= bus.max_exp;
        qf_p1    <= bus.Q_frac;
      end
    end
  end

  // Small leading-one positions saturate the shift so diff never drops below DIFF_MIN.
  always_comb begin
    shamt_c = '0;
    pre_c   = '0;
    if (!carry_p1 && !zero_p1) begin
      if (lead_p1 >= 5'd8) begin
        shamt_c    = 5'd23 - lead_p1;
        pre_c.diff = signed'(lead_p1 - 5'd23);
      end else begin
        shamt_c    = IDX_W'(SHIFT_CAP);
        pre_c.diff = DIFF_MIN;
      end
    end
    shifted_c = mag_p1[LOD_W-1:0] << shamt_c;
    pre_c.win = carry_p1 ? mag_p1[SUM_W-1:SUM_W-MANT_W] : shifted_c[LOD_W-1:LOD_W-MANT_W];
  end

`ifdef NORM_ROUND_EN
  always_comb begin
    guard_c  = carry_p1 ? mag_p1[SUM_W-MANT_W-1] : shifted_c[LOD_W-MANT_W-1];
    sticky_c = carry_p1 ? |mag_p1[SUM_W-MANT_W-2:0] : |shifted_c[LOD_W-MANT_W-2:0];
    post_c   = round_rne(pre_c, guard_c, sticky_c);
  end
`else
  logic unused_trunc;
  assign unused_trunc = ^shifted_c[LOD_W-MANT_W-1:0];
  assign post_c       = pre_c;
`endif

  // ---- stage 2: register the normalized window and exponent adjustment ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      win_p2   <= '0;
      diff_p2  <= '0;
      carry_p2 <= 1'b0;
      sign_p2  <= 1'b0;
      exp_p2   <= '0;
      qf_p2    <= '0;
    end else begin
      if (s2_advance) vld_p2 <= vld_p1;
      if (vld_p1 && s2_advance) begin
        win_p2   <= post_c.win;
        diff_p2  <= post_c.diff;
        carry_p2 <= carry_p1;
        sign_p2  <= sign_p1;
        exp_p2   <= exp_p1;
        qf_p2    <= qf_p1;
      end
    end
  end

  assign bus.out_valid              = vld_p2;
  assign bus.norm_sum_with_leading1 = win_p2;
  assign bus.signed_exp_diff        = diff_p2;
  assign bus.exp_carry              = carry_p2;
  assign bus.sign_o                 = sign_p2;
  assign bus.max_exp_o              = exp_p2;
  assign bus.Q_frac_o               = qf_p2;

endmodule

// File: tb/tb_mac_norm_shift.sv
// Scoreboard bench for mac_norm_shift; honours NORM_ROUND_EN in its reference model.
module tb_mac_norm_shift;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_norm_shift_if bus ();

  mac_norm_shift dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          base_acc;
  logic        rnd_done;
  logic [31:0] sb_q[$];
  logic        hold_pend = 1'b0;
  logic [31:0] held = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_out();
    return {3'b0, bus.norm_sum_with_leading1, bus.signed_exp_diff, bus.exp_carry,
            bus.sign_o, bus.max_exp_o, bus.Q_frac_o};
  endfunction

  function automatic logic [31:0] model(input logic [24:0] m, input logic s,
                                        input logic [5:0] e, input logic [4:0] q);
    logic [10:0] w;
    logic [4:0]  d;
    logic        g;
    logic        st;
    logic [23:0] sh;
    int          p;
    w = '0; d = '0; g = 1'b0; st = 1'b0; p = -1;
    if (m[24]) begin
      w  = m[24:14];
      g  = m[13];
      st = |m[12:0];
    end else if (m != 25'd0) begin
      for (int i = 0; i < 24; i++) if (m[i]) p = i;
      sh = m[23:0] << ((p >= 8) ? (23 - p) : 16);
      w  = sh[23:13];
      g  = sh[12];
      st = |sh[11:0];
      d  = (p >= 8) ? 5'(p - 23) : 5'h10;
    end
`ifdef NORM_ROUND_EN
    if (g && (st || w[0])) begin
      if (w == 11'h7FF) begin
        w = 11'h400;
        d = d + 5'd1;
      end else begin
        w = w + 11'd1;
      end
    end
`endif
    return {3'b0, w, d, m[24], s, e, q};
  endfunction

  // Output monitor: compares each consumed beat and checks stalled beats stay put.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", pack_out(), held);
      end
      hold_pend <= bus.out_valid & ~bus.out_ready;
      held      <= pack_out();
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) check("beat", pack_out(), sb_q.pop_front());
      end
    end
  end

  task automatic send(input logic [24:0] m, input logic s, input logic [5:0] e, input logic [4:0] q);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.sum_mag  = m;
    bus.sign     = s;
    bus.max_exp  = e;
    bus.Q_frac   = q;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
    end
    check("accept", 32'(acc), 32'd1);
    if (acc) begin
      sb_q.push_back(model(m, s, e, q));
      n_acc++;
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] vecs [9];
    vecs = '{25'h1000000, 25'h0000400, 25'h0000001, 25'h0000000, 25'h0FFFFFF,
             25'h1FFFFFF, 25'h00000FF, 25'h0000100, 25'h1006001};

    bus.in_valid = 1'b0;
    bus.sum_mag  = '0;
    bus.sign     = 1'b0;
    bus.max_exp  = '0;
    bus.Q_frac   = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_data", pack_out(), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-cycle latency on an empty pipeline.
    send(25'h0800000, 1'b1, 6'h21, 5'h03);
    @(negedge clk);
    check("lat_c1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_c2", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors back-to-back with downstream always ready.
    for (int i = 0; i < 9; i++) send(vecs[i], 1'(i), 6'(i * 7), 5'(i * 3));
    drain();

    // Stall: downstream blocks for 3 cycles while 4 beats are offered.
    base_acc = n_acc;
    bus.out_ready = 1'b0;
    fork
      begin
        send(25'h0000400, 1'b0, 6'h01, 5'h01);
        send(25'h0000001, 1'b1, 6'h02, 5'h02);
        send(25'h1000000, 1'b0, 6'h03, 5'h03);
        send(25'h0123456, 1'b1, 6'h04, 5'h04);
      end
      begin
        repeat (3) @(negedge clk);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_accepted", 32'(n_acc - base_acc), 32'd2);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Random beats with random downstream back-pressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(25'($urandom) >> $urandom_range(0, 24), 1'($urandom), 6'($urandom), 5'($urandom));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Reset with both stages full drops the in-flight beats immediately.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(25'h0000800, 1'b1, 6'h3F, 5'h1F);
    send(25'h0400000, 1'b1, 6'h3E, 5'h1E);
    #1;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    check("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("async_rst_data", pack_out(), 32'd0);
    sb_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(25'h0000400, 1'b0, 6'h15, 5'h0A);
    @(negedge clk);
    check("post_rst_lat_c1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("post_rst_lat_c2", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
